// File: rtl/hex_scroll_ctrl_if.sv
// Board-side signal bundle for the scrolling HEX controller: switch/key
// controls in, segment drives and window position out.
interface hex_scroll_ctrl_if;
  logic       EN_DISP;
  logic       RUN;
  logic       DIR;
  logic       STEP;
  logic [0:6] HEX0;
  logic [0:6] HEX1;
  logic [0:6] HEX2;
  logic [0:6] HEX3;
  logic [2:0] POS;

  modport master (
    output EN_DISP, RUN, DIR, STEP,
    input  HEX0, HEX1, HEX2, HEX3, POS
  );

  modport slave (
    input  EN_DISP, RUN, DIR, STEP,
    output HEX0, HEX1, HEX2, HEX3, POS
  );
endinterface

// File: rtl/hex_scroll_ctrl.sv
// Scrolls a 4-character window of the circular message "FPGA    " across HEX3..HEX0.
// Optional pause-mode blinking is enabled by defining HEX_SCROLL_BLINK_EN.
module hex_scroll_ctrl #(
  parameter int TICK_DIV = 12500000
) (
  input  logic           CLOCK_50,
  input  logic           RST,
  hex_scroll_ctrl_if.slave bus
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);
  localparam logic [0:6]    SEG_OFF = 7'b1111111;

  typedef enum logic [1:0] {
    ST_BLANK,
    ST_RUN,
    ST_PAUSE
  } state_t;

  function automatic logic [0:6] msg_rom(input logic [2:0] idx);
    logic [0:6] seg;
    case (idx)
      3'd0:    seg = 7'b0111000;
      3'd1:    seg = 7'b0011000;
      3'd2:    seg = 7'b0100001;
      3'd3:    seg = 7'b0001000;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_presc;
  logic          r_step_prev;
  logic [2:0]    r_pos;
  logic [0:6]    r_hex [4];
  logic [0:6]    w_win [4];
  logic          w_tick;
  logic          w_step_p;
  logic          w_run_entry;
  logic          w_advance;
  logic [2:0]    w_pos_next;
  logic          w_hidden;
  logic          w_blank_out;

  always_comb begin
    w_state_next = ST_BLANK;
    if (bus.EN_DISP) begin
      w_state_next = bus.RUN ? ST_RUN : ST_PAUSE;
    end
  end

  assign w_tick      = (r_presc == TERM);
  assign w_step_p    = bus.STEP & ~r_step_prev;
  assign w_run_entry = (w_state_next == ST_RUN) && (r_state != ST_RUN);
  assign w_advance   = ((r_state == ST_RUN) && w_tick) ||
                       ((r_state == ST_PAUSE) && w_step_p);
  assign w_pos_next  = bus.DIR ? (r_pos - 3'd1) : (r_pos + 3'd1);

  // Digit gi shows msg[POS + 3 - gi]; the 3-bit sum wraps the message mod 8.
  for (genvar gi = 0; gi < 4; gi++) begin : g_win
    assign w_win[gi] = msg_rom(r_pos + 3'(3 - gi));
  end

`ifdef HEX_SCROLL_BLINK_EN
  logic r_blink_vis;

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      r_blink_vis <= 1'b1;
    end else if (r_state == ST_PAUSE) begin
      if (w_tick) begin
        r_blink_vis <= ~r_blink_vis;
      end
    end else begin
      r_blink_vis <= 1'b1;
    end
  end

  assign w_hidden = (r_state == ST_PAUSE) && !r_blink_vis;
`else
  assign w_hidden = 1'b0;
`endif

  assign w_blank_out = (r_state == ST_BLANK) || w_hidden;

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      r_state     <= ST_BLANK;
      r_pos       <= 3'd0;
      r_presc     <= '0;
      r_step_prev <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_hex[i] <= SEG_OFF;
      end
    end else begin
      r_state     <= w_state_next;
      r_step_prev <= bus.STEP;

      // Clearing on RUN entry places the first advance exactly TICK_DIV cycles later.
      if ((r_state == ST_BLANK) || w_run_entry || w_tick) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + CW'(1);
      end

      if (w_advance) begin
        r_pos <= w_pos_next;
      end

      for (int i = 0; i < 4; i++) begin
        r_hex[i] <= w_blank_out ? SEG_OFF : w_win[i];
      end
    end
  end

  assign bus.HEX0 = r_hex[0];
  assign bus.HEX1 = r_hex[1];
  assign bus.HEX2 = r_hex[2];
  assign bus.HEX3 = r_hex[3];
  assign bus.POS  = r_pos;

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Scoreboard bench for hex_scroll_ctrl (TICK_DIV=4): the stimulus queues
// cycle-stamped expectations, a negedge monitor pops and compares them.
module tb_hex_scroll_ctrl;

  localparam logic [6:0] SF = 7'b0111000;
  localparam logic [6:0] SP = 7'b0011000;
  localparam logic [6:0] SG = 7'b0100001;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SB = 7'b1111111;

  localparam logic [27:0] W_FPGA = {SF, SP, SG, SA};
  localparam logic [27:0] W_PGAB = {SP, SG, SA, SB};
  localparam logic [27:0] W_BFPG = {SB, SF, SP, SG};
  localparam logic [27:0] W_BBFP = {SB, SB, SF, SP};
  localparam logic [27:0] W_GABB = {SG, SA, SB, SB};
  localparam logic [27:0] W_BBBF = {SB, SB, SB, SF};
  localparam logic [27:0] W_BBBB = {SB, SB, SB, SB};

`ifdef HEX_SCROLL_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  typedef struct {
    int          due;
    string       name;
    logic [2:0]  pos;
    logic [27:0] hex;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];

  hex_scroll_ctrl_if bus();

  hex_scroll_ctrl #(.TICK_DIV(4)) dut (
    .CLOCK_50 (clk),
    .RST      (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int due, input string name, input logic [2:0] pos,
                      input logic [27:0] hex);
    exp_t e;
    e.due  = due;
    e.name = name;
    e.pos  = pos;
    e.hex  = hex;
    q.push_back(e);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // In pause, the blink phase is hidden for 4 cycles starting at cycle 44, every 8.
  function automatic logic [27:0] ph(input int k, input logic [27:0] w);
    if (BLINK && k >= 44 && (((k - 44) / 4) % 2) == 0) return W_BBBB;
    return w;
  endfunction

  always @(negedge clk) begin
    logic [27:0] act_hex;
    exp_t        e;
    act_hex = {bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      n_cmp++;
      if (e.due != cyc) begin
        n_bad++;
        $display("FAIL %s: checked late at cycle %0d, required cycle %0d", e.name, cyc, e.due);
      end else if (bus.POS !== e.pos || act_hex !== e.hex) begin
        n_bad++;
        $display("FAIL %s @%0d: POS=%0d HEX3..0=%b required POS=%0d HEX3..0=%b",
                 e.name, cyc, bus.POS, act_hex, e.pos, e.hex);
      end else begin
        $display("ok   %s @%0d: POS=%0d HEX3..0=%b", e.name, cyc, bus.POS, act_hex);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: bench still running at cycle %0d, required finish by cycle 140", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    bus.EN_DISP = 1'b1;
    bus.RUN     = 1'b1;
    bus.DIR     = 1'b0;
    bus.STEP    = 1'b0;
    push(1, "reset", 3'd0, W_BBBB);
    wait_until(2);
    rst = 1'b0;

    // RUN entered at cycle 3; first advance 4 cycles later.
    push(4, "first_win", 3'd0, W_FPGA);
    push(6, "pre_tick", 3'd0, W_FPGA);
    push(7, "tick1_pos", 3'd1, W_FPGA);
    push(8, "tick1_hex", 3'd1, W_PGAB);
    push(31, "pos7", 3'd7, W_BBFP);
    push(35, "wrap_pos", 3'd0, W_BFPG);
    push(36, "wrap_hex", 3'd0, W_FPGA);
    wait_until(36);
    bus.DIR = 1'b1;
    push(39, "dir1_pos", 3'd7, W_FPGA);
    push(40, "dir1_hex", 3'd7, W_BFPG);

    wait_until(40);
    bus.RUN = 1'b0;
    bus.DIR = 1'b0;
    push(42, "pause_entry", 3'd7, W_BFPG);
    wait_until(42);
    bus.STEP = 1'b1;
    push(43, "step_wrap", 3'd0, W_BFPG);
    push(44, "step_hex", 3'd0, ph(44, W_FPGA));
    push(52, "step_held", 3'd0, ph(52, W_FPGA));
    wait_until(52);
    bus.STEP = 1'b0;
    push(56, "ticks_idle", 3'd0, ph(56, W_FPGA));
    wait_until(56);
    bus.STEP = 1'b1;
    bus.DIR  = 1'b1;
    push(57, "step_back", 3'd7, ph(57, W_FPGA));
    wait_until(57);
    bus.STEP = 1'b0;
    for (int k = 58; k <= 75; k++) push(k, "pause_win", 3'd7, ph(k, W_BFPG));

    wait_until(76);
    bus.RUN = 1'b1;
    wait_until(77);
    bus.STEP = 1'b1;
    wait_until(78);
    bus.STEP = 1'b0;
    push(80, "run_step_ign", 3'd7, W_BFPG);
    push(81, "run_tick", 3'd6, W_BFPG);

    push(98, "blank_lag", 3'd2, W_GABB);
    push(99, "blanked", 3'd2, W_BBBB);
    push(105, "blank_hold", 3'd2, W_BBBB);
    wait_until(97);
    bus.EN_DISP = 1'b0;
    wait_until(105);
    bus.EN_DISP = 1'b1;
    push(107, "restore", 3'd2, W_GABB);
    push(110, "resume", 3'd1, W_GABB);
    push(111, "resume_hex", 3'd1, W_PGAB);
    wait_until(111);
    bus.DIR = 1'b0;

    push(127, "pre_rst", 3'd5, W_BBBF);
    push(128, "async_rst", 3'd0, W_BBBB);
    wait_until(128);
    #1 rst = 1'b1;
    wait_until(130);
    rst = 1'b0;
    push(132, "post_rst", 3'd0, W_FPGA);
    push(135, "post_rst_tick", 3'd1, W_FPGA);
    wait_until(138);

    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: never checked by cycle %0d, required at cycle %0d", e.name, cyc, e.due);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hex_scroll_ctrl.md
# hex_scroll_ctrl

Sequencing controller for the DE1 four-digit seven-segment bank (HEX3..HEX0). It holds an 8-character circular message, "FPGA" followed by four blanks, and drives a 4-character window of it onto the displays. The window scrolls at a prescaled tick rate, or one position per step pulse while paused. It sits between the board switches/keys and the HEX pins, and replaces per-digit static decoders with a single sequenced source.

## Interface
- TICK_DIV, default 12500000: CLOCK_50 cycles per scroll tick (4 Hz at 50 MHz); must be ≥2.
- CLOCK_50  in  1  system clock; all logic is on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- EN_DISP  in  1  display enable; 0 forces the display blank.
- RUN  in  1  1 = auto-scroll, 0 = paused.
- DIR  in  1  0 = text moves left (POS increments), 1 = text moves right (POS decrements).
- STEP  in  1  synchronous, level input; each 0→1 edge requests one step.
- HEX0, HEX1, HEX2, HEX3  out  [0:6] each  segment drive, active-low; bit 0 = a … bit 6 = g.
- POS  out  3  current window start index into the message.

## Operation
- Message ROM, index 0..7:
  - 0 = F = 0111000
  - 1 = P = 0011000
  - 2 = G = 0100001
  - 3 = A = 0001000
  - 4..7 = blank = 1111111
- Window mapping, indices mod 8: HEX3 = msg[POS], HEX2 = msg[POS+1], HEX1 = msg[POS+2], HEX0 = msg[POS+3]. POS=0 displays "FPGA".
- Prescaler: a counter of ceil(log2(TICK_DIV)) bits. It counts 0..TICK_DIV-1, and `tick` is asserted for the single cycle when the count equals TICK_DIV-1. The count then wraps to 0.
- Step edge detector: a register holds the previous STEP value. `step_p` = STEP & ~STEP_prev.
- State machine, 3 states (next state depends only on EN_DISP and RUN):
  - BLANK: next state when EN_DISP=0, from any state. HEX outputs all 1111111, POS holds, prescaler held at 0.
  - RUN: next state when EN_DISP=1 and RUN=1. On `tick`, POS moves ±1 mod 8 according to DIR. `step_p` is ignored.
  - PAUSE: next state when EN_DISP=1 and RUN=0. The prescaler keeps counting. POS moves ±1 mod 8 (per DIR) on each `step_p`; `tick` does not move POS.
- Wrap-around: POS 7 +1 = 0, and POS 0 −1 = 7.
- DIR is sampled in the same cycle as the advancing `tick`/`step_p`. A DIR change mid-interval only affects the next advance.

## Timing
- Reset values (asserted asynchronously, held while RST=1):
  - state = BLANK
  - POS = 0
  - prescaler = 0
  - STEP_prev = 0
  - blink phase = visible
  - HEX0..HEX3 = 1111111
- State register: updates on the first clock edge after an input change, i.e. 1-cycle latency.
- Entering RUN from PAUSE or BLANK clears the prescaler to 0. The first advance occurs exactly TICK_DIV cycles after the state becomes RUN.
- POS is registered. The HEX outputs are registered from the current POS and state, so HEX lags POS by 1 cycle.
- STEP held high produces exactly one step; a new edge requires STEP to return to 0 for ≥1 cycle.
- An edge detected while not in PAUSE is discarded, not queued.
- EN_DISP falling mid-interval: the display blanks 2 cycles later (state, then HEX register). POS is preserved and resumes from the same value.
- RST mid-operation: immediate return to the reset values; no pending step or tick survives.

## Configuration
- HEX_SCROLL_BLINK_EN defined:
  - In PAUSE, a blink-phase flop toggles on every `tick`.
  - While the phase is "hidden", all HEX outputs = 1111111.
  - The phase is forced to visible on entry to PAUSE and in all other states.
  - A step does not alter the phase.
- HEX_SCROLL_BLINK_EN undefined: PAUSE displays the window steadily; no blink flop is synthesized.

## Test plan
- Reset, with TICK_DIV=4, EN_DISP=1, RUN=1, DIR=0 and RST released: POS=0 and HEX3..HEX0 = F,P,G,A. POS=1 appears 4 cycles after RUN state entry, then HEX3..HEX0 = P,G,A,blank one cycle later.
- Wrap-around: run 8 ticks with DIR=0 and POS returns to 0. Starting from POS=0 with DIR=1, one tick gives POS=7 and HEX3..HEX0 = blank,F,P,G.
- Pause stepping: RUN=0, then STEP held high for 10 cycles gives exactly one advance (POS 0→1). Subsequent ticks do not change POS. A STEP pulse while RUN=1 leaves POS unchanged.
- Blanking: with POS=2, set EN_DISP=0; HEX reads all 1111111 within 2 cycles. Restore EN_DISP=1 and the display shows G,A,blank,blank with POS=2 unchanged.
- Async reset mid-run: assert RST between clock edges at POS=5. HEX immediately goes to 1111111 and POS=0 without waiting for a clock edge.
- With HEX_SCROLL_BLINK_EN, TICK_DIV=4, PAUSE: the window is visible for 4 cycles, blank for 4, visible for 4. Without the macro, the window stays steady for 16 cycles.
